// File: rtl/shmem_arbiter.sv
// Round-robin arbiter sharing one shared-memory read port and one write port
// between N_REQ SIMD processors. The read grant is a lock held while the owner
// keeps its request up; the write grant is released after a single strobe.
module shmem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int BUS_W  = 80,
  parameter int SIZE_W = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [N_REQ-1:0]          i_req_rd,
  input  logic [N_REQ-1:0]          i_req_wr,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*BUS_W-1:0]    i_wr_data,
  input  logic [N_REQ*SIZE_W-1:0]   i_wr_size,
  input  logic [N_REQ-1:0]          i_wr_en,
  output logic [N_REQ-1:0]          o_grant_rd,
  output logic [N_REQ-1:0]          o_grant_wr,
  output logic [ADDR_W-1:0]         o_mem_rd_addr,
  input  logic [BUS_W-1:0]          i_mem_rd_data,
  output logic [BUS_W-1:0]          o_rd_data,
  output logic [ADDR_W-1:0]         o_mem_wr_addr,
  output logic [BUS_W-1:0]          o_mem_wr_data,
  output logic [SIZE_W-1:0]         o_mem_wr_size,
  output logic                      o_mem_wr_en,
  output logic [$clog2(N_REQ)-1:0]  o_rd_owner,
  output logic [$clog2(N_REQ)-1:0]  o_wr_owner
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          rd_state, rd_state_n;
  state_t          wr_state, wr_state_n;
  logic [OW-1:0]   rd_owner, rd_owner_n;
  logic [OW-1:0]   rd_ptr,   rd_ptr_n;
  logic [OW-1:0]   wr_owner, wr_owner_n;
  logic [OW-1:0]   wr_ptr,   wr_ptr_n;
  logic [N_REQ-1:0] rd_others;
  logic [N_REQ-1:0] wr_others;
  logic             rd_busy;
  logic             wr_busy;
  logic             rd_owner_req;
  logic             wr_owner_req;
  logic             wr_owner_en;
  logic             wr_release;

  // First set bit of req searching upward from ptr+1, wrapping modulo N_REQ.
  // Callers only use the result when req has at least one bit set.
  function automatic logic [OW-1:0] pick_next(input logic [N_REQ-1:0] req,
                                              input logic [OW-1:0]    ptr);
    logic [OW-1:0] win;
    logic [OW-1:0] idx;
    logic          found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign rd_busy      = (rd_state == BUSY);
  assign wr_busy      = (wr_state == BUSY);
  assign rd_owner_req = i_req_rd[rd_owner];
  assign wr_owner_req = i_req_wr[wr_owner];
  assign wr_owner_en  = i_wr_en[wr_owner];
  // A write owner lets go after its strobe or when it withdraws its request.
  assign wr_release   = !wr_owner_req || wr_owner_en;
  // Handover candidates never include the outgoing owner.
  assign rd_others    = i_req_rd & ~(N_REQ'(1) << rd_owner);
  assign wr_others    = i_req_wr & ~(N_REQ'(1) << wr_owner);

  // Read port state, owner and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_state <= IDLE;
      rd_owner <= '0;
      rd_ptr   <= OW'(N_REQ - 1);
    end else begin
      rd_state <= rd_state_n;
      rd_owner <= rd_owner_n;
      rd_ptr   <= rd_ptr_n;
    end
  end

  // Read port next state: lock held until the owner's request falls.
  always_comb begin
    rd_state_n = rd_state;
    rd_owner_n = rd_owner;
    rd_ptr_n   = rd_ptr;
    case (rd_state)
      IDLE: begin
        if (|i_req_rd) begin
          rd_owner_n = pick_next(i_req_rd, rd_ptr);
          rd_ptr_n   = rd_owner_n;
          rd_state_n = BUSY;
        end
      end
      BUSY: begin
        if (!rd_owner_req) begin
          if (|rd_others) begin
            rd_owner_n = pick_next(rd_others, rd_ptr);
            rd_ptr_n   = rd_owner_n;
          end else begin
            rd_state_n = IDLE;
          end
        end
      end
      default: rd_state_n = IDLE;
    endcase
  end

  // Write port state, owner and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_state <= IDLE;
      wr_owner <= '0;
      wr_ptr   <= OW'(N_REQ - 1);
    end else begin
      wr_state <= wr_state_n;
      wr_owner <= wr_owner_n;
      wr_ptr   <= wr_ptr_n;
    end
  end

  // Write port next state: one-shot ownership released after the strobe.
  always_comb begin
    wr_state_n = wr_state;
    wr_owner_n = wr_owner;
    wr_ptr_n   = wr_ptr;
    case (wr_state)
      IDLE: begin
        if (|i_req_wr) begin
          wr_owner_n = pick_next(i_req_wr, wr_ptr);
          wr_ptr_n   = wr_owner_n;
          wr_state_n = BUSY;
        end
      end
      BUSY: begin
        if (wr_release) begin
          if (|wr_others) begin
            wr_owner_n = pick_next(wr_others, wr_ptr);
            wr_ptr_n   = wr_owner_n;
          end else begin
            wr_state_n = IDLE;
          end
        end
      end
      default: wr_state_n = IDLE;
    endcase
  end

  // Grants follow the owner's live request so they drop in the same cycle.
  always_comb begin
    o_grant_rd = '0;
    o_grant_wr = '0;
    if (rd_busy && rd_owner_req) begin
      o_grant_rd = N_REQ'(1) << rd_owner;
    end
    if (wr_busy && wr_owner_req) begin
      o_grant_wr = N_REQ'(1) << wr_owner;
    end
  end

  // Memory-side read address steered from the read owner.
  always_comb begin
    o_mem_rd_addr = '0;
    if (rd_busy) begin
      o_mem_rd_addr = i_addr[rd_owner*ADDR_W +: ADDR_W];
    end
  end

  // Memory-side write bus steered from the write owner, quiet when idle.
  always_comb begin
    o_mem_wr_addr = '0;
    o_mem_wr_data = '0;
    o_mem_wr_size = '0;
    o_mem_wr_en   = 1'b0;
    if (wr_busy) begin
      o_mem_wr_addr = i_addr[wr_owner*ADDR_W +: ADDR_W];
      o_mem_wr_data = i_wr_data[wr_owner*BUS_W +: BUS_W];
      o_mem_wr_size = i_wr_size[wr_owner*SIZE_W +: SIZE_W];
      o_mem_wr_en   = wr_owner_req && wr_owner_en;
    end
  end

  assign o_rd_data  = i_mem_rd_data;
  assign o_rd_owner = rd_owner;
  assign o_wr_owner = wr_owner;

endmodule

// File: tb/tb_shmem_arbiter.sv
// Self-checking bench for shmem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural arbitration model.
module tb_shmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 80;
  localparam int SW = 3;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_rd, req_wr, wr_en;
  logic [N*AW-1:0] addr;
  logic [N*BW-1:0] wr_data;
  logic [N*SW-1:0] wr_size;
  logic [BW-1:0]   mem_rd_data;
  logic [N-1:0]    grant_rd, grant_wr;
  logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
  logic [BW-1:0]   rd_data, mem_wr_data;
  logic [SW-1:0]   mem_wr_size;
  logic            mem_wr_en;
  logic [OW-1:0]   rd_owner, wr_owner;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: who owns each port and who was served last.
  bit m_rd_busy, m_wr_busy;
  int m_rd_own, m_wr_own, m_rd_last, m_wr_last;

  shmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .BUS_W(BW), .SIZE_W(SW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_addr(addr), .i_wr_data(wr_data), .i_wr_size(wr_size), .i_wr_en(wr_en),
    .o_grant_rd(grant_rd), .o_grant_wr(grant_wr),
    .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data), .o_rd_data(rd_data),
    .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
    .o_mem_wr_size(mem_wr_size), .o_mem_wr_en(mem_wr_en),
    .o_rd_owner(rd_owner), .o_wr_owner(wr_owner)
  );

  always #5 clk = ~clk;

  function automatic bit bitOf(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Round-robin rule: first requester after the last one served, wrapping.
  function automatic int findWinner(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (bitOf(req, idx)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_rd_busy = 1'b0;
    m_wr_busy = 1'b0;
    m_rd_own  = 0;
    m_wr_own  = 0;
    m_rd_last = N - 1;
    m_wr_last = N - 1;
  endtask

  // Apply the arbitration rules for one clock edge using the current inputs.
  task automatic modelEdge();
    logic [N-1:0] others;
    int w;
    if (!rstn) begin
      modelReset();
    end else begin
      if (!m_rd_busy) begin
        w = findWinner(req_rd, m_rd_last);
        if (w >= 0) begin
          m_rd_busy = 1'b1; m_rd_own = w; m_rd_last = w;
        end
      end else if (!bitOf(req_rd, m_rd_own)) begin
        others = req_rd & ~(N'(1) << m_rd_own);
        w = findWinner(others, m_rd_last);
        if (w >= 0) begin
          m_rd_own = w; m_rd_last = w;
        end else begin
          m_rd_busy = 1'b0;
        end
      end
      if (!m_wr_busy) begin
        w = findWinner(req_wr, m_wr_last);
        if (w >= 0) begin
          m_wr_busy = 1'b1; m_wr_own = w; m_wr_last = w;
        end
      end else if (!bitOf(req_wr, m_wr_own) || bitOf(wr_en, m_wr_own)) begin
        others = req_wr & ~(N'(1) << m_wr_own);
        w = findWinner(others, m_wr_last);
        if (w >= 0) begin
          m_wr_own = w; m_wr_last = w;
        end else begin
          m_wr_busy = 1'b0;
        end
      end
    end
  endtask

  // Compare every DUT output with what the model predicts for this cycle.
  task automatic checkOutput();
    logic [N-1:0]  eg_rd, eg_wr;
    logic [AW-1:0] e_rd_addr, e_wr_addr;
    logic [BW-1:0] e_wr_data;
    logic [SW-1:0] e_wr_size;
    logic          e_wr_en;
    eg_rd = '0; eg_wr = '0;
    e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_wr_size = '0; e_wr_en = 1'b0;
    if (m_rd_busy) begin
      e_rd_addr = addr[m_rd_own*AW +: AW];
      if (bitOf(req_rd, m_rd_own)) eg_rd = N'(1) << m_rd_own;
    end
    if (m_wr_busy) begin
      e_wr_addr = addr[m_wr_own*AW +: AW];
      e_wr_data = wr_data[m_wr_own*BW +: BW];
      e_wr_size = wr_size[m_wr_own*SW +: SW];
      if (bitOf(req_wr, m_wr_own)) eg_wr = N'(1) << m_wr_own;
      e_wr_en = bitOf(req_wr, m_wr_own) && bitOf(wr_en, m_wr_own);
    end
    chk("grant_rd", 128'(grant_rd), 128'(eg_rd));
    chk("grant_wr", 128'(grant_wr), 128'(eg_wr));
    chk("mem_rd_addr", 128'(mem_rd_addr), 128'(e_rd_addr));
    chk("rd_data", 128'(rd_data), 128'(mem_rd_data));
    chk("mem_wr_addr", 128'(mem_wr_addr), 128'(e_wr_addr));
    chk("mem_wr_data", 128'(mem_wr_data), 128'(e_wr_data));
    chk("mem_wr_size", 128'(mem_wr_size), 128'(e_wr_size));
    chk("mem_wr_en", 128'(mem_wr_en), 128'(e_wr_en));
    if (m_rd_busy) chk("rd_owner", 128'(rd_owner), 128'(m_rd_own));
    if (m_wr_busy) chk("wr_owner", 128'(wr_owner), 128'(m_wr_own));
  endtask

  // One clock cycle with the currently driven inputs; returns at the negedge.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    req_rd = '0; req_wr = '0; wr_en = '0;
    addr = '0; wr_data = '0; wr_size = '0; mem_rd_data = '0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    clearInputs();
    modelReset();
    #1;
    chk("rst_grant_rd", 128'(grant_rd), 128'(0));
    chk("rst_grant_wr", 128'(grant_wr), 128'(0));
    chk("rst_rd_addr", 128'(mem_rd_addr), 128'(0));
    chk("rst_wr_en", 128'(mem_wr_en), 128'(0));
    chk("rst_rd_owner", 128'(rd_owner), 128'(0));
    chk("rst_wr_owner", 128'(wr_owner), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [N-1:0] t2_req  [13];
  logic [N-1:0] t2_gnt  [13];

  initial begin
    t2_req = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1011, 4'b1001,
               4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    t2_gnt = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
               4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

    // Single read held three cycles by requester 2.
    doReset();
    addr[2*AW +: AW] = 16'h0040;
    req_rd = 4'b0100;
    #1; chk("t1_idle_grant", 128'(grant_rd), 128'(0));
    applyStimulus();
    #1; chk("t1_grant", 128'(grant_rd), 128'(4'b0100));
    chk("t1_addr", 128'(mem_rd_addr), 128'(16'h0040));
    applyStimulus();
    #1; chk("t1_grant_hold", 128'(grant_rd), 128'(4'b0100));
    applyStimulus();
    req_rd = '0;
    #1; chk("t1_grant_drop", 128'(grant_rd), 128'(0));
    applyStimulus();
    #1; chk("t1_idle_addr", 128'(mem_rd_addr), 128'(0));
    applyStimulus();

    // Read contention: order 0,1,3 then re-raised 0.
    doReset();
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(16'h0100 + i);
    for (int c = 0; c < 13; c++) begin
      req_rd = t2_req[c];
      #1; chk($sformatf("t2_grant_c%0d", c + 1), 128'(grant_rd), 128'(t2_gnt[c]));
      applyStimulus();
    end

    // Back-to-back one-shot writes from requesters 0 and 1.
    doReset();
    wr_size[0*SW +: SW] = 3'd2;
    wr_size[1*SW +: SW] = 3'd5;
    wr_data[0*BW +: BW] = 80'h0000_1111_2222_3333_4444;
    wr_data[1*BW +: BW] = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
    addr[0*AW +: AW] = 16'h0010;
    addr[1*AW +: AW] = 16'h0020;
    req_wr = 4'b0011;
    applyStimulus();
    wr_en = 4'b0001;
    #1; chk("t3_wr_en0", 128'(mem_wr_en), 128'(1));
    chk("t3_grant0", 128'(grant_wr), 128'(4'b0001));
    chk("t3_size0", 128'(mem_wr_size), 128'(3'd2));
    applyStimulus();
    req_wr = 4'b0010; wr_en = 4'b0010;
    #1; chk("t3_wr_en1", 128'(mem_wr_en), 128'(1));
    chk("t3_grant1", 128'(grant_wr), 128'(4'b0010));
    chk("t3_size1", 128'(mem_wr_size), 128'(3'd5));
    chk("t3_addr1", 128'(mem_wr_addr), 128'(16'h0020));
    applyStimulus();
    req_wr = '0; wr_en = '0;
    #1; chk("t3_idle_wr_en", 128'(mem_wr_en), 128'(0));
    chk("t3_idle_size", 128'(mem_wr_size), 128'(0));
    applyStimulus();

    // Concurrent read by 0 and write by 2.
    doReset();
    req_rd = 4'b0001; req_wr = 4'b0100;
    applyStimulus();
    #1; chk("t4_grant_rd", 128'(grant_rd), 128'(4'b0001));
    chk("t4_grant_wr", 128'(grant_wr), 128'(4'b0100));
    chk("t4_rd_owner", 128'(rd_owner), 128'(0));
    chk("t4_wr_owner", 128'(wr_owner), 128'(2));
    applyStimulus();
    req_rd = '0; req_wr = '0;
    applyStimulus();

    // Lone owner abandons the read lock.
    doReset();
    addr[1*AW +: AW] = 16'h1234;
    req_rd = 4'b0010;
    applyStimulus();
    #1; chk("t5_grant", 128'(grant_rd), 128'(4'b0010));
    applyStimulus();
    req_rd = '0;
    #1; chk("t5_grant_drop", 128'(grant_rd), 128'(0));
    chk("t5_addr_busy", 128'(mem_rd_addr), 128'(16'h1234));
    applyStimulus();
    #1; chk("t5_addr_idle", 128'(mem_rd_addr), 128'(0));
    applyStimulus();

    // Asynchronous reset while requester 3 holds the lock.
    doReset();
    req_rd = 4'b1000; req_wr = 4'b1000;
    applyStimulus();
    #1; chk("t6_hold", 128'(grant_rd), 128'(4'b1000));
    #1; rstn = 1'b0; modelReset();
    #1; chk("t6_rst_grant_rd", 128'(grant_rd), 128'(0));
    chk("t6_rst_grant_wr", 128'(grant_wr), 128'(0));
    @(negedge clk);
    rstn = 1'b1; req_rd = 4'b1100; req_wr = '0;
    applyStimulus();
    #1; chk("t6_ptr_reset", 128'(grant_rd), 128'(4'b0100));
    applyStimulus();
    doReset();
    req_rd = 4'b1101;
    applyStimulus();
    #1; chk("t6_ptr_reset_req0", 128'(grant_rd), 128'(4'b0001));
    applyStimulus();

    // Randomized traffic with sticky requests.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      req_rd = req_rd ^ (N'($urandom()) & N'($urandom()));
      req_wr = req_wr ^ (N'($urandom()) & N'($urandom()));
      wr_en  = N'($urandom()) & N'($urandom());
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]    = AW'($urandom());
        wr_data[i*BW +: BW] = rand80();
        wr_size[i*SW +: SW] = SW'($urandom());
      end
      mem_rd_data = rand80();
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
